// File: rtl/triumph_pkg.sv
// ============================================================================
// triumph_pkg : shared opcode, funct3 and ALU-op definitions for the ID stage
// Build option : TRIUMPH_RV32E_EN (16-entry register file, index checking)
// Revision     : 1.0
// ============================================================================
`default_nettype none

package triumph_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;

`ifdef TRIUMPH_RV32E_EN
    localparam int NUM_REGS = 16;
`else
    localparam int NUM_REGS = 32;
`endif

    function automatic logic reg_idx_ok(input logic [4:0] idx);
        return ({1'b0, idx} < 6'(NUM_REGS));
    endfunction

    // i_alt is instr[30]; SUB only exists for register-register ADD
    function automatic alu_op_e alu_from_f3(input logic [2:0] i_f3,
                                            input logic       i_alt,
                                            input logic       i_allow_sub);
        alu_op_e op;
        case (i_f3)
            F3_ADD:  op = (i_alt && i_allow_sub) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = i_alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/triumph_register_file.sv
// ============================================================================
// triumph_register_file : 2 async read / 1 sync write GPR file, x0 hardwired,
//                         write-through bypass; 16 entries with TRIUMPH_RV32E_EN
// Revision              : 1.0
// ============================================================================
`default_nettype none

module triumph_register_file
    import triumph_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [4:0]      i_raddr_a,
    input  logic [4:0]      i_raddr_b,
    output logic [XLEN-1:0] o_rdata_a,
    output logic [XLEN-1:0] o_rdata_b,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    localparam int AW = $clog2(NUM_REGS);

    logic [XLEN-1:0] r_regs [NUM_REGS];
    logic            w_wr_ok;

    assign w_wr_ok = i_we && (i_waddr != 5'd0) && reg_idx_ok(i_waddr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_waddr[AW-1:0]] <= i_wdata;
        end
    end

    // Out-of-range indices read as zero so the datapath stays deterministic
    always_comb begin
        o_rdata_a = '0;
        o_rdata_b = '0;
        if (i_raddr_a != 5'd0 && reg_idx_ok(i_raddr_a)) begin
            o_rdata_a = (w_wr_ok && i_waddr == i_raddr_a) ? i_wdata
                                                           : r_regs[i_raddr_a[AW-1:0]];
        end
        if (i_raddr_b != 5'd0 && reg_idx_ok(i_raddr_b)) begin
            o_rdata_b = (w_wr_ok && i_waddr == i_raddr_b) ? i_wdata
                                                           : r_regs[i_raddr_b[AW-1:0]];
        end
    end

endmodule

`default_nettype wire

// File: rtl/triumph_id_stage.sv
// ============================================================================
// triumph_id_stage : RV32I decode stage with register file, ID/EX register,
//                    load-use stall and flush; TRIUMPH_RV32E_EN enables RV32E
// Revision         : 1.0
// ============================================================================
`default_nettype none

module triumph_id_stage
    import triumph_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            instr_valid_i,
    input  logic [31:0]     instr_data_i,
    input  logic [31:0]     pc_i,
    output logic            stall_o,
    input  logic            flush_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_waddr_i,
    input  logic [XLEN-1:0] wb_wdata_i,
    output logic            valid_ex_o,
    output logic [31:0]     pc_ex_o,
    output logic [3:0]      alu_op_ex_o,
    output logic            alu_src_imm_ex_o,
    output logic [XLEN-1:0] rs1_data_ex_o,
    output logic [XLEN-1:0] rs2_data_ex_o,
    output logic [31:0]     imm_ex_o,
    output logic [4:0]      rd_addr_ex_o,
    output logic            rd_we_ex_o,
    output logic            is_load_ex_o,
    output logic            is_store_ex_o,
    output logic            is_branch_ex_o,
    output logic            is_jump_ex_o,
    output logic [2:0]      funct3_ex_o,
    output logic            illegal_ex_o
);

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [31:0]     w_imm_i;
    logic [31:0]     w_imm_s;
    logic [31:0]     w_imm_b;
    logic [31:0]     w_imm_u;
    logic [31:0]     w_imm_j;

    alu_op_e         w_alu_op;
    logic            w_src_imm;
    logic [31:0]     w_imm;
    logic            w_writes_rd;
    logic            w_rd_we;
    logic            w_ld;
    logic            w_st;
    logic            w_br;
    logic            w_jp;
    logic            w_ill;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_f7_ok;
    logic            w_hazard;
    logic            w_accept;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    logic            r_valid;
    logic [31:0]     r_pc;
    alu_op_e         r_alu_op;
    logic            r_src_imm;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [31:0]     r_imm;
    logic [4:0]      r_rd;
    logic            r_rd_we;
    logic            r_ld;
    logic            r_st;
    logic            r_br;
    logic            r_jp;
    logic [2:0]      r_f3;
    logic            r_ill;

    assign w_opcode = instr_data_i[6:0];
    assign w_rd     = instr_data_i[11:7];
    assign w_f3     = instr_data_i[14:12];
    assign w_rs1    = instr_data_i[19:15];
    assign w_rs2    = instr_data_i[24:20];
    assign w_f7     = instr_data_i[31:25];
    assign w_f7_ok  = (w_f7 == 7'h00) || (w_f7 == 7'h20);

    assign w_imm_i = {{20{instr_data_i[31]}}, instr_data_i[31:20]};
    assign w_imm_s = {{20{instr_data_i[31]}}, instr_data_i[31:25], instr_data_i[11:7]};
    assign w_imm_b = {{19{instr_data_i[31]}}, instr_data_i[31], instr_data_i[7],
                      instr_data_i[30:25], instr_data_i[11:8], 1'b0};
    assign w_imm_u = {instr_data_i[31:12], 12'h000};
    assign w_imm_j = {{11{instr_data_i[31]}}, instr_data_i[31], instr_data_i[19:12],
                      instr_data_i[20], instr_data_i[30:21], 1'b0};

    always_comb begin
        w_alu_op    = ALU_ADD;
        w_src_imm   = 1'b0;
        w_imm       = 32'h0;
        w_writes_rd = 1'b0;
        w_ld        = 1'b0;
        w_st        = 1'b0;
        w_br        = 1'b0;
        w_jp        = 1'b0;
        w_ill       = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_alu_op    = ALU_PASSB;
                w_src_imm   = 1'b1;
                w_imm       = w_imm_u;
                w_writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                w_src_imm   = 1'b1;
                w_imm       = w_imm_u;
                w_writes_rd = 1'b1;
            end
            OPC_JAL: begin
                w_imm       = w_imm_j;
                w_writes_rd = 1'b1;
                w_jp        = 1'b1;
            end
            OPC_JALR: begin
                w_src_imm   = 1'b1;
                w_imm       = w_imm_i;
                w_writes_rd = 1'b1;
                w_jp        = 1'b1;
                w_use_rs1   = 1'b1;
            end
            OPC_BRANCH: begin
                w_alu_op    = ALU_SUB;
                w_imm       = w_imm_b;
                w_br        = 1'b1;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
            end
            OPC_LOAD: begin
                w_src_imm   = 1'b1;
                w_imm       = w_imm_i;
                w_writes_rd = 1'b1;
                w_ld        = 1'b1;
                w_use_rs1   = 1'b1;
            end
            OPC_STORE: begin
                w_src_imm   = 1'b1;
                w_imm       = w_imm_s;
                w_st        = 1'b1;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
            end
            OPC_OP_IMM: begin
                w_alu_op    = alu_from_f3(w_f3, instr_data_i[30], 1'b0);
                w_src_imm   = 1'b1;
                w_imm       = w_imm_i;
                w_writes_rd = 1'b1;
                w_use_rs1   = 1'b1;
                // Shift-immediates carry their funct7 in imm[11:5]
                if ((w_f3 == F3_SLL || w_f3 == F3_SR) && !w_f7_ok) begin
                    w_ill = 1'b1;
                end
            end
            OPC_OP: begin
                w_alu_op    = alu_from_f3(w_f3, instr_data_i[30], 1'b1);
                w_writes_rd = 1'b1;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_ill       = !w_f7_ok;
            end
            OPC_FENCE: begin
                w_alu_op    = ALU_ADD;
            end
            OPC_SYSTEM: begin
                w_ill       = 1'b1;
            end
            default: begin
                w_ill       = 1'b1;
            end
        endcase
`ifdef TRIUMPH_RV32E_EN
        if ((w_writes_rd && !reg_idx_ok(w_rd)) ||
            (w_use_rs1 && !reg_idx_ok(w_rs1)) ||
            (w_use_rs2 && !reg_idx_ok(w_rs2))) begin
            w_ill = 1'b1;
        end
`endif
        w_rd_we = w_writes_rd && !w_ill && (w_rd != 5'd0);
    end

    assign w_hazard = r_valid && r_ld && (r_rd != 5'd0) && instr_valid_i &&
                      ((w_use_rs1 && w_rs1 == r_rd) || (w_use_rs2 && w_rs2 == r_rd));
    assign stall_o  = w_hazard && !flush_i;
    assign w_accept = instr_valid_i && !w_hazard && !flush_i;

    triumph_register_file #(
        .XLEN (XLEN)
    ) u_regfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_raddr_a (w_rs1),
        .i_raddr_b (w_rs2),
        .o_rdata_a (w_rs1_data),
        .o_rdata_b (w_rs2_data),
        .i_we      (wb_we_i),
        .i_waddr   (wb_waddr_i),
        .i_wdata   (wb_wdata_i)
    );

    // Payload fields are captured every cycle; only the qualifying flags are masked
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_pc       <= RESET_PC;
            r_alu_op   <= ALU_ADD;
            r_src_imm  <= 1'b0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= 32'h0;
            r_rd       <= 5'd0;
            r_rd_we    <= 1'b0;
            r_ld       <= 1'b0;
            r_st       <= 1'b0;
            r_br       <= 1'b0;
            r_jp       <= 1'b0;
            r_f3       <= 3'd0;
            r_ill      <= 1'b0;
        end else begin
            r_valid    <= w_accept;
            r_pc       <= pc_i;
            r_alu_op   <= w_alu_op;
            r_src_imm  <= w_src_imm;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
            r_imm      <= w_imm;
            r_rd       <= w_rd;
            r_rd_we    <= w_accept && w_rd_we;
            r_ld       <= w_accept && w_ld;
            r_st       <= w_accept && w_st;
            r_br       <= w_accept && w_br;
            r_jp       <= w_accept && w_jp;
            r_f3       <= w_f3;
            r_ill      <= w_accept && w_ill;
        end
    end

    assign valid_ex_o       = r_valid;
    assign pc_ex_o          = r_pc;
    assign alu_op_ex_o      = r_alu_op;
    assign alu_src_imm_ex_o = r_src_imm;
    assign rs1_data_ex_o    = r_rs1_data;
    assign rs2_data_ex_o    = r_rs2_data;
    assign imm_ex_o         = r_imm;
    assign rd_addr_ex_o     = r_rd;
    assign rd_we_ex_o       = r_rd_we;
    assign is_load_ex_o     = r_ld;
    assign is_store_ex_o    = r_st;
    assign is_branch_ex_o   = r_br;
    assign is_jump_ex_o     = r_jp;
    assign funct3_ex_o      = r_f3;
    assign illegal_ex_o     = r_ill;

endmodule

`default_nettype wire

// File: tb/tb_triumph_id_stage.sv
// ============================================================================
// tb_triumph_id_stage : table-driven, scoreboarded bench for triumph_id_stage
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_triumph_id_stage;
    import triumph_pkg::*;

    localparam logic [31:0] C_RESET_PC = 32'h0;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        alu_op_e     alu;
        logic        src;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we, ld, st, br, jp, ill;
        logic [2:0]  f3;
        logic [31:0] d1, d2;
        logic        c_ops, c_imm, c_data, c_pc, c_f3;
        int          id;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    logic        clk;
    logic        rst_i;
    logic        instr_valid_i;
    logic [31:0] instr_data_i;
    logic [31:0] pc_i;
    logic        stall_o;
    logic        flush_i;
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        valid_ex_o;
    logic [31:0] pc_ex_o;
    logic [3:0]  alu_op_ex_o;
    logic        alu_src_imm_ex_o;
    logic [31:0] rs1_data_ex_o;
    logic [31:0] rs2_data_ex_o;
    logic [31:0] imm_ex_o;
    logic [4:0]  rd_addr_ex_o;
    logic        rd_we_ex_o;
    logic        is_load_ex_o;
    logic        is_store_ex_o;
    logic        is_branch_ex_o;
    logic        is_jump_ex_o;
    logic [2:0]  funct3_ex_o;
    logic        illegal_ex_o;

    int   total = 0;
    int   bad   = 0;
    int   n_step = 0;
    exp_t sb[$];
    vec_t tbl[15];

    logic        nx_we    = 1'b0;
    logic [4:0]  nx_waddr = 5'd0;
    logic [31:0] nx_wdata = 32'h0;

    triumph_id_stage #(
        .XLEN     (32),
        .RESET_PC (C_RESET_PC)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .instr_valid_i    (instr_valid_i),
        .instr_data_i     (instr_data_i),
        .pc_i             (pc_i),
        .stall_o          (stall_o),
        .flush_i          (flush_i),
        .wb_we_i          (wb_we_i),
        .wb_waddr_i       (wb_waddr_i),
        .wb_wdata_i       (wb_wdata_i),
        .valid_ex_o       (valid_ex_o),
        .pc_ex_o          (pc_ex_o),
        .alu_op_ex_o      (alu_op_ex_o),
        .alu_src_imm_ex_o (alu_src_imm_ex_o),
        .rs1_data_ex_o    (rs1_data_ex_o),
        .rs2_data_ex_o    (rs2_data_ex_o),
        .imm_ex_o         (imm_ex_o),
        .rd_addr_ex_o     (rd_addr_ex_o),
        .rd_we_ex_o       (rd_we_ex_o),
        .is_load_ex_o     (is_load_ex_o),
        .is_store_ex_o    (is_store_ex_o),
        .is_branch_ex_o   (is_branch_ex_o),
        .is_jump_ex_o     (is_jump_ex_o),
        .funct3_ex_o      (funct3_ex_o),
        .illegal_ex_o     (illegal_ex_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (step %0d): got %h expected %h", nm, id, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input alu_op_e alu, input logic src,
                                input logic [31:0] imm, input logic [4:0] rd,
                                input logic we, input logic ld, input logic st,
                                input logic br, input logic jp, input logic ill,
                                input logic [2:0] f3, input logic cops, input logic cimm);
        exp_t e;
        e.v = v;   e.pc = 32'h0; e.alu = alu; e.src = src; e.imm = imm; e.rd = rd;
        e.we = we; e.ld = ld; e.st = st; e.br = br; e.jp = jp; e.ill = ill; e.f3 = f3;
        e.d1 = 32'h0; e.d2 = 32'h0;
        e.c_ops = cops; e.c_imm = cimm; e.c_data = v; e.c_pc = 1'b0; e.c_f3 = v;
        e.id = 0;
        return e;
    endfunction

    function automatic exp_t with_data(input exp_t e_in, input logic [31:0] d1, input logic [31:0] d2);
        exp_t e = e_in;
        e.d1 = d1; e.d2 = d2; e.c_data = 1'b1;
        return e;
    endfunction

    function automatic exp_t bubble();
        return mk(1'b0, ALU_ADD, 1'b0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 0, 3'd0, 1'b0, 1'b0);
    endfunction

    function automatic exp_t rst_exp();
        exp_t e = mk(1'b0, ALU_ADD, 1'b0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 0, 3'd0, 1'b1, 1'b1);
        e.pc = C_RESET_PC; e.c_pc = 1'b1; e.c_data = 1'b1; e.c_f3 = 1'b1;
        return e;
    endfunction

    function automatic vec_t vec(input logic [31:0] instr, input exp_t e);
        vec_t t;
        t.instr = instr; t.e = e;
        return t;
    endfunction

    task automatic cmp(input exp_t e);
        chk("valid",   e.id, 32'(valid_ex_o),     32'(e.v));
        chk("rd_we",   e.id, 32'(rd_we_ex_o),     32'(e.we));
        chk("load",    e.id, 32'(is_load_ex_o),   32'(e.ld));
        chk("store",   e.id, 32'(is_store_ex_o),  32'(e.st));
        chk("branch",  e.id, 32'(is_branch_ex_o), 32'(e.br));
        chk("jump",    e.id, 32'(is_jump_ex_o),   32'(e.jp));
        chk("illegal", e.id, 32'(illegal_ex_o),   32'(e.ill));
        if (e.c_pc)  chk("pc", e.id, pc_ex_o, e.pc);
        if (e.c_f3)  chk("funct3", e.id, 32'(funct3_ex_o), 32'(e.f3));
        if (e.c_imm) chk("imm", e.id, imm_ex_o, e.imm);
        if (e.c_ops) begin
            chk("alu_op",  e.id, 32'(alu_op_ex_o),      32'(e.alu));
            chk("src_imm", e.id, 32'(alu_src_imm_ex_o), 32'(e.src));
            chk("rd_addr", e.id, 32'(rd_addr_ex_o),     32'(e.rd));
        end
        if (e.c_data) begin
            chk("rs1_data", e.id, rs1_data_ex_o, e.d1);
            chk("rs2_data", e.id, rs2_data_ex_o, e.d2);
        end
    endtask

    // One cycle: check the previous cycle's result, drive new inputs, queue expectation
    task automatic step(input logic r, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic fl, input exp_t e_in,
                        input int exp_stall);
        exp_t e;
        exp_t got;
        @(negedge clk);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            cmp(got);
        end
        e = e_in;
        if (e.v) begin
            e.pc   = pc;
            e.c_pc = 1'b1;
        end
        e.id = n_step;
        n_step++;
        rst_i         = r;
        instr_valid_i = v;
        instr_data_i  = ins;
        pc_i          = pc;
        flush_i       = fl;
        wb_we_i       = nx_we;
        wb_waddr_i    = nx_waddr;
        wb_wdata_i    = nx_wdata;
        nx_we         = 1'b0;
        sb.push_back(e);
        #1;
        if (exp_stall >= 0) chk("stall", e.id, 32'(stall_o), 32'(exp_stall));
    endtask

    initial begin
        exp_t e_lw;
        exp_t e_add6;
        exp_t got;

        rst_i = 1'b1; instr_valid_i = 1'b0; instr_data_i = 32'h0; pc_i = 32'h0;
        flush_i = 1'b0; wb_we_i = 1'b0; wb_waddr_i = 5'd0; wb_wdata_i = 32'h0;

        tbl[0]  = vec(32'h00500093, mk(1, ALU_ADD, 1, 32'd5,        5'd1, 1,0,0,0,0,0, 3'd0, 1, 1));
        tbl[1]  = vec(32'hFE000EE3, mk(1, ALU_ADD, 0, 32'hFFFFFFFC, 5'd0, 0,0,0,1,0,0, 3'd0, 0, 1));
        tbl[2]  = vec(32'h800000EF, mk(1, ALU_ADD, 0, 32'hFFF00000, 5'd1, 1,0,0,0,1,0, 3'd0, 0, 1));
        tbl[3]  = vec(32'h12345037, mk(1, ALU_ADD, 0, 32'h12345000, 5'd0, 0,0,0,0,0,0, 3'd5, 0, 1));
        tbl[4]  = vec(32'h00000073, mk(1, ALU_ADD, 0, 32'h0,        5'd0, 0,0,0,0,0,1, 3'd0, 0, 0));
        tbl[5]  = vec(32'h00108133, mk(1, ALU_ADD, 0, 32'h0,        5'd2, 1,0,0,0,0,0, 3'd0, 1, 0));
        tbl[6]  = vec(32'h402081B3, mk(1, ALU_SUB, 0, 32'h0,        5'd3, 1,0,0,0,0,0, 3'd0, 1, 0));
        tbl[7]  = vec(32'h4030D213, mk(1, ALU_SRA, 1, 32'h00000403, 5'd4, 1,0,0,0,0,0, 3'd5, 1, 1));
        tbl[8]  = vec(32'h02309213, mk(1, ALU_ADD, 0, 32'h0,        5'd0, 0,0,0,0,0,1, 3'd1, 0, 0));
        tbl[9]  = vec(32'h022082B3, mk(1, ALU_ADD, 0, 32'h0,        5'd0, 0,0,0,0,0,1, 3'd0, 0, 0));
        tbl[10] = vec(32'h0020A423, mk(1, ALU_ADD, 0, 32'd8,        5'd0, 0,0,1,0,0,0, 3'd2, 0, 1));
        tbl[11] = vec(32'h0000000F, mk(1, ALU_ADD, 0, 32'h0,        5'd0, 0,0,0,0,0,0, 3'd0, 0, 0));
`ifdef TRIUMPH_RV32E_EN
        tbl[12] = vec(32'h00100893, mk(1, ALU_ADD, 0, 32'h0,        5'd0, 0,0,0,0,0,1, 3'd0, 0, 0));
`else
        tbl[12] = vec(32'h00100893, mk(1, ALU_ADD, 1, 32'd1,        5'd17,1,0,0,0,0,0, 3'd0, 1, 1));
`endif
        tbl[13] = vec(32'h004100E7, mk(1, ALU_ADD, 0, 32'd4,        5'd1, 1,0,0,0,1,0, 3'd0, 0, 1));
        tbl[14] = vec(32'h0000A283, mk(1, ALU_ADD, 1, 32'h0,        5'd5, 1,1,0,0,0,0, 3'd2, 1, 1));

        e_lw   = tbl[14].e;
        e_add6 = mk(1, ALU_ADD, 0, 32'h0, 5'd6, 1,0,0,0,0,0, 3'd0, 1, 0);

        // Reset state
        step(1, 0, 32'h0, 32'h0, 0, rst_exp(), -1);
        step(1, 0, 32'h0, 32'h0, 0, rst_exp(), 0);

        // Decode table
        for (int i = 0; i < 15; i++) begin
            step(0, 1, tbl[i].instr, 32'(i * 4), 0, tbl[i].e, 0);
        end

        // Write-through and x0 hardwiring
        nx_we = 1; nx_waddr = 5'd3; nx_wdata = 32'hDEADBEEF;
        step(0, 1, 32'h00318133, 32'h100, 0,
             with_data(mk(1, ALU_ADD, 0, 0, 5'd2, 1,0,0,0,0,0, 3'd0, 1, 0), 32'hDEADBEEF, 32'hDEADBEEF), 0);
        nx_we = 1; nx_waddr = 5'd0; nx_wdata = 32'h12345678;
        step(0, 1, 32'h00000133, 32'h104, 0,
             with_data(mk(1, ALU_ADD, 0, 0, 5'd2, 1,0,0,0,0,0, 3'd0, 1, 0), 32'h0, 32'h0), 0);
        nx_we = 1; nx_waddr = 5'd5; nx_wdata = 32'h00000055;
        step(0, 1, 32'h00018233, 32'h108, 0,
             with_data(mk(1, ALU_ADD, 0, 0, 5'd4, 1,0,0,0,0,0, 3'd0, 1, 0), 32'hDEADBEEF, 32'h0), 0);
        step(0, 1, 32'h00000233, 32'h10C, 0,
             with_data(mk(1, ALU_ADD, 0, 0, 5'd4, 1,0,0,0,0,0, 3'd0, 1, 0), 32'h0, 32'h0), 0);

        // Load-use: one stall cycle, bubble, then add reads x5
        step(0, 1, 32'h0000A283, 32'h110, 0, e_lw, 0);
        step(0, 1, 32'h00028333, 32'h114, 0, bubble(), 1);
        step(0, 1, 32'h00028333, 32'h114, 0, with_data(e_add6, 32'h55, 32'h0), 0);
        // U-type whose rs1 field matches the load rd does not stall
        step(0, 1, 32'h0000A283, 32'h118, 0, e_lw, 0);
        begin
            exp_t e_lui = mk(1, ALU_ADD, 0, 32'h00028000, 5'd7, 1,0,0,0,0,0, 3'd0, 0, 1);
            e_lui.c_data = 1'b0;
            step(0, 1, 32'h000283B7, 32'h11C, 0, e_lui, 0);
        end
        step(0, 1, 32'h0000A283, 32'h120, 0, e_lw, 0);
        step(0, 1, 32'h00038333, 32'h124, 0, e_add6, 0);

        // Flush beats a pending load-use stall
        step(0, 1, 32'h0000A283, 32'h128, 0, e_lw, 0);
        step(0, 1, 32'h00028333, 32'h12C, 1, bubble(), 0);
        step(0, 1, 32'h00038333, 32'h130, 0, e_add6, 0);

        // Reset mid-operation drops the hazard and clears the register file
        step(0, 1, 32'h0000A283, 32'h134, 0, e_lw, 0);
        step(1, 1, 32'h00028333, 32'h138, 0, rst_exp(), -1);
        step(0, 1, 32'h00028333, 32'h138, 0, with_data(e_add6, 32'h0, 32'h0), 0);
        step(0, 0, 32'h00028333, 32'h13C, 0, bubble(), 0);

        @(negedge clk);
        while (sb.size() != 0) begin
            got = sb.pop_front();
            cmp(got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/triumph_id_stage.md
Name: triumph_id_stage

Overview:
RV32I decode stage, directly downstream of the instruction-fetch stage. Consumes the fetched instruction word and its valid flag, then decodes opcode, register indices and immediates. Reads operands from an internal 2R/1W register file that is written back from the WB stage. Registers everything into the ID/EX pipeline register and generates load-use stall and flush handling.

Parameters:
XLEN, 32, datapath width
RESET_PC, 32'h0, value of pc_ex_o after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
instr_valid_i  in  1  instruction from IF is valid
instr_data_i  in  32  instruction word from IF
pc_i  in  32  address of instr_data_i
stall_o  out  1  IF must hold pc/instruction next cycle
flush_i  in  1  taken branch/jump resolved in EX; kill ID contents
wb_we_i  in  1  register-file write enable
wb_waddr_i  in  5  write index
wb_wdata_i  in  32  write data
valid_ex_o  out  1  ID/EX slot holds a real instruction
pc_ex_o  out  32  pc of instruction in EX
alu_op_ex_o  out  4  ALU operation (package enum)
alu_src_imm_ex_o  out  1  operand B = immediate
rs1_data_ex_o  out  32  operand A
rs2_data_ex_o  out  32  operand B / store data
imm_ex_o  out  32  sign-extended immediate
rd_addr_ex_o  out  5  destination index
rd_we_ex_o  out  1  instruction writes rd (forced 0 when rd==0)
is_load_ex_o, is_store_ex_o, is_branch_ex_o, is_jump_ex_o  out  1 each  class flags
funct3_ex_o  out  3  width/branch condition
illegal_ex_o  out  1  undecodable opcode/funct

Behaviour:
- Synchronous reset (rst_i sampled on rising edge): every *_ex_o output is 0, except pc_ex_o=RESET_PC; stall_o=0; all register-file entries cleared.
- Latency: an instruction accepted in cycle N appears on *_ex_o in cycle N+1.
- Accept condition: instr_valid_i && !stall_o && !flush_i. When not accepted, the next valid_ex_o is 0 (bubble). All other ID/EX fields are don't-care but must be driven deterministically: rd_we, load/store/branch/jump/illegal forced 0.
- Decode: opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP and FENCE (FENCE is treated as a NOP). SYSTEM and any other opcode set illegal_ex_o=1 and rd_we=0.
- Decode of funct7: bit 30 selects SUB and SRA. Any other nonzero funct7 on OP sets illegal. SLLI/SRLI/SRAI with imm[11:5] not 0x00/0x20 set illegal.
- Immediates: I/S/B/U/J formats, all sign-extended from instr[31]; bit 0 of B and J is 0.
- Register file: x0 reads 0 and ignores writes. Write occurs on the rising edge when wb_we_i=1. Reads are write-through: a same-cycle write to the index being read returns wb_wdata_i.
- Load-use hazard:
  - stall_o=1 combinationally when valid_ex_o && is_load_ex_o && rd_addr_ex_o!=0 && instr_valid_i, and the decoded instruction uses rs1 or rs2 equal to rd_addr_ex_o.
  - Usage is per format: U/J use neither; I/LOAD/JALR use rs1 only.
  - Stall lasts exactly one cycle, because the bubble clears the condition.
  - IF holds instr_data_i/pc_i stable while stall_o=1.
- Flush: flush_i has priority over stall. In the next cycle valid_ex_o=0, and stall_o is 0 while flush_i=1.
- Reset mid-operation: same as power-up reset; any in-flight load hazard is dropped.

Optional Feature:
TRIUMPH_RV32E_EN
- Defined: register file has 16 entries. Any used rs1/rs2/rd index with bit 4 set raises illegal_ex_o=1, rd_we=0. Writes with wb_waddr_i[4]=1 are ignored.
- Undefined: full 32-entry RV32I register file; no index check.

Decomposition:
- Package triumph_pkg:
  - opcode localparams (OPC_LUI ... OPC_SYSTEM)
  - 4-bit ALU op constants: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB
  - funct3 constants for branches and loads/stores
- Sub-module triumph_register_file: 2 async read ports, 1 sync write, x0 hardwiring, write-through bypass, RV32E sizing.

Test Plan:
1. Reset, then instr_data_i=32'h00500093 (addi x1,x0,5), pc_i=0 -> next cycle: valid_ex_o=1, alu_op=ADD, imm_ex_o=5, rd_addr=1, rd_we=1, rs1_data=0.
2. wb_we_i=1, waddr=3, wdata=32'hDEADBEEF, same cycle as instr 32'h00318133 (add x2,x3,x3) -> rs1_data_ex_o=rs2_data_ex_o=32'hDEADBEEF (write-through). Separately, write to x0 -> x0 still reads 0.
3. lw x5,0(x1) followed by add x6,x5,x0:
   - stall_o=1 for exactly one cycle.
   - Bubble (valid_ex_o=0) follows the load.
   - The add issues next with rs1 index 5.
   - lw then add x6,x7,x0 -> no stall.
4. flush_i=1 together with a valid instruction and an active load-use stall -> next valid_ex_o=0, stall_o=0 during flush; the following valid instruction issues normally.
5. Immediates: 32'hFE000EE3 (beq, offset -4) -> imm_ex_o=32'hFFFFFFFC. 32'h800000EF (jal) -> imm_ex_o=32'hFFF00000. 32'h12345037 (lui) -> imm_ex_o=32'h12345000.
6. Illegal/feature checks: 32'h00000073 (ecall) -> illegal_ex_o=1, rd_we=0. With TRIUMPH_RV32E_EN: addi x17,x0,1 -> illegal_ex_o=1. Without the macro: legal, rd_addr=17.
